// File: rtl/vmode_ctrl.sv
// Video-mode controller: holds the active horizontal/vertical timing mode and applies
// requested modes at a frame boundary. Optional request validation under VMODE_CHECK_EN.
module vmode_ctrl #(
    parameter int HW           = 12,
    parameter int VW           = 12,
    parameter int RESET_CYCLES = 4,
    parameter int TIMEOUT      = 1 << 20,
    parameter logic [4*HW-1:0] DEF_HMODE = {HW'(640), HW'(656), HW'(752), HW'(800)},
    parameter logic [4*VW-1:0] DEF_VMODE = {VW'(480), VW'(490), VW'(492), VW'(525)}
) (
    input  logic            i_pixclk,
    input  logic            i_reset,
    input  logic            i_req,
    input  logic [4*HW-1:0] i_hmode,
    input  logic [4*VW-1:0] i_vmode,
    input  logic            i_newframe,
    output logic            o_busy,
    output logic            o_ack,
    output logic            o_err,
    output logic            o_vga_reset,
    output logic [HW-1:0]   o_hm_width,
    output logic [HW-1:0]   o_hm_porch,
    output logic [HW-1:0]   o_hm_synch,
    output logic [HW-1:0]   o_hm_raw,
    output logic [VW-1:0]   o_vm_height,
    output logic [VW-1:0]   o_vm_porch,
    output logic [VW-1:0]   o_vm_synch,
    output logic [VW-1:0]   o_vm_raw,
    output logic [1:0]      o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    // One counter serves both the reset-pulse length (RST) and the boundary timeout (PEND).
    localparam int CW = $clog2(TIMEOUT + RESET_CYCLES + 1);
    localparam logic [CW-1:0] CNT_RST  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            ack_pend, ack_pend_n;
    logic            ack_q, ack_n;
    logic            cap, sw, req_ok;
    logic [4*HW-1:0] hmode_q, sh_hmode;
    logic [4*VW-1:0] vmode_q, sh_vmode;

`ifdef VMODE_CHECK_EN
    logic err_q;

    assign req_ok = (HW'(16) < i_hmode[4*HW-1 -: HW])
                 && (i_hmode[4*HW-1 -: HW] < i_hmode[3*HW-1 -: HW])
                 && (i_hmode[3*HW-1 -: HW] < i_hmode[2*HW-1 -: HW])
                 && (i_hmode[2*HW-1 -: HW] < i_hmode[HW-1:0])
                 && (VW'(16) < i_vmode[4*VW-1 -: VW])
                 && (i_vmode[4*VW-1 -: VW] < i_vmode[3*VW-1 -: VW])
                 && (i_vmode[3*VW-1 -: VW] < i_vmode[2*VW-1 -: VW])
                 && (i_vmode[2*VW-1 -: VW] < i_vmode[VW-1:0]);

    always_ff @(posedge i_pixclk) begin
        if (i_reset) err_q <= 1'b0;
        else         err_q <= cap && !req_ok;
    end
    assign o_err = err_q;
`else
    assign req_ok = 1'b1;
    assign o_err  = 1'b0;
`endif

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state    <= ST_RST;
            cnt      <= CNT_RST;
            hmode_q  <= DEF_HMODE;
            vmode_q  <= DEF_VMODE;
            sh_hmode <= '0;
            sh_vmode <= '0;
            ack_pend <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ack_pend <= ack_pend_n;
            ack_q    <= ack_n;
            if (cap) begin
                sh_hmode <= i_hmode;
                sh_vmode <= i_vmode;
            end
            if (sw) begin
                hmode_q <= sh_hmode;
                vmode_q <= sh_vmode;
            end
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ack_pend_n = ack_pend;
        ack_n      = 1'b0;
        cap        = 1'b0;
        sw         = 1'b0;
        case (state)
            ST_RST: begin
                if (cnt <= CW'(1)) begin
                    state_n    = ST_RUN;
                    ack_n      = ack_pend;
                    ack_pend_n = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_RUN: begin
                if (i_req) begin
                    cap = 1'b1;
                    if (req_ok) begin
                        state_n = ST_PEND;
                        cnt_n   = '0;
                    end
                end
            end
            ST_PEND: begin
                // A strobe on the capture edge was sampled in RUN, so only PEND strobes land here.
                if (i_newframe || cnt == CNT_LAST) begin
                    sw         = 1'b1;
                    state_n    = ST_RST;
                    cnt_n      = CNT_RST;
                    ack_pend_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_RST;
                cnt_n   = CNT_RST;
            end
        endcase
    end

    assign o_busy      = (state != ST_RUN);
    assign o_vga_reset = (state == ST_RST);
    assign o_ack       = ack_q;
    assign o_dbg_state = state;

    assign o_hm_width  = hmode_q[4*HW-1 -: HW];
    assign o_hm_porch  = hmode_q[3*HW-1 -: HW];
    assign o_hm_synch  = hmode_q[2*HW-1 -: HW];
    assign o_hm_raw    = hmode_q[HW-1:0];
    assign o_vm_height = vmode_q[4*VW-1 -: VW];
    assign o_vm_porch  = vmode_q[3*VW-1 -: VW];
    assign o_vm_synch  = vmode_q[2*VW-1 -: VW];
    assign o_vm_raw    = vmode_q[VW-1:0];

endmodule
